// File: rtl/supply_seq_driver.sv
// Ordered supply enable driver for *_w_sup wrapper cells: VSS, then VDD, then input release on power-up,
// reverse order on power-down, with an unsequenced emergency drop on supply fault.
module supply_seq_driver #(
   parameter int VDD_DLY = 8,
   parameter int SETTLE  = 16,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pwr_req,
   input  logic sup_fault,
   input  logic in_data,
   output logic vss_en,
   output logic vdd_en,
   output logic dut_in,
   output logic pwr_good,
   output logic busy,
   output logic fault
);

   typedef enum logic [2:0] {
      S_OFF,
      S_VSS_ON,
      S_VDD_ON,
      S_GOOD,
      S_DRAIN,
      S_VDD_OFF,
      S_FAULT
   } state_t;

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   generate
      if (VDD_DLY < 1 || VDD_DLY > CNT_MAX) begin : g_bad_vdd_dly
         $error("supply_seq_driver: VDD_DLY=%0d outside 1..%0d", VDD_DLY, CNT_MAX);
      end
      if (SETTLE < 1 || SETTLE > CNT_MAX) begin : g_bad_settle
         $error("supply_seq_driver: SETTLE=%0d outside 1..%0d", SETTLE, CNT_MAX);
      end
   endgenerate

   // Terminal counts: a delay of N cycles ends when the counter reaches N-1.
   localparam logic [CNT_W-1:0] VDD_LAST    = CNT_W'(VDD_DLY - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             in_gate;
   logic             vss_en_nxt, vdd_en_nxt, in_gate_nxt, pwr_good_nxt, busy_nxt, fault_nxt;

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      state_nxt = state;
      if (sup_fault && state != S_FAULT) begin
         state_nxt = S_FAULT;
      end else begin
         case (state)
            S_OFF:     if (pwr_req) state_nxt = S_VSS_ON;
            // A dropped request wins over a terminal count so a supply is never raised unrequested.
            S_VSS_ON: begin
               if (!pwr_req)              state_nxt = S_OFF;
               else if (cnt == VDD_LAST)  state_nxt = S_VDD_ON;
            end
            S_VDD_ON: begin
               if (!pwr_req)                 state_nxt = S_VDD_OFF;
               else if (cnt == SETTLE_LAST)  state_nxt = S_GOOD;
            end
            S_GOOD:    if (!pwr_req) state_nxt = S_DRAIN;
            S_DRAIN:   if (cnt == SETTLE_LAST) state_nxt = S_VDD_OFF;
            S_VDD_OFF: if (cnt == VDD_LAST) state_nxt = S_OFF;
            S_FAULT:   if (!sup_fault && !pwr_req) state_nxt = S_OFF;
            default:   state_nxt = S_OFF;
         endcase
      end
   end

   // Counter restarts on every state entry and saturates instead of wrapping.
   always_comb begin
      cnt_nxt = cnt;
      if (state_nxt != state) begin
         cnt_nxt = '0;
      end else if (cnt != CNT_SAT) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // Outputs decode the state being entered so they change on the same edge as the state.
   always_comb begin
      vss_en_nxt   = 1'b0;
      vdd_en_nxt   = 1'b0;
      in_gate_nxt  = 1'b0;
      pwr_good_nxt = 1'b0;
      busy_nxt     = 1'b0;
      fault_nxt    = 1'b0;
      case (state_nxt)
         S_VSS_ON: begin
            vss_en_nxt = 1'b1;
            busy_nxt   = 1'b1;
         end
         S_VDD_ON, S_DRAIN: begin
            vss_en_nxt = 1'b1;
            vdd_en_nxt = 1'b1;
            busy_nxt   = 1'b1;
         end
         S_GOOD: begin
            vss_en_nxt   = 1'b1;
            vdd_en_nxt   = 1'b1;
            in_gate_nxt  = 1'b1;
            pwr_good_nxt = 1'b1;
         end
         S_VDD_OFF: begin
            vss_en_nxt = 1'b1;
            busy_nxt   = 1'b1;
         end
         S_FAULT:   fault_nxt = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (rst) begin
         state    <= S_OFF;
         cnt      <= '0;
         vss_en   <= 1'b0;
         vdd_en   <= 1'b0;
         in_gate  <= 1'b0;
         pwr_good <= 1'b0;
         busy     <= 1'b0;
         fault    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         vss_en   <= vss_en_nxt;
         vdd_en   <= vdd_en_nxt;
         in_gate  <= in_gate_nxt;
         pwr_good <= pwr_good_nxt;
         busy     <= busy_nxt;
         fault    <= fault_nxt;
      end
   end

   assign dut_in = in_gate & in_data;

endmodule

// File: tb/tb_supply_seq_driver.sv
// Bench for supply_seq_driver: supply-ladder model checked every cycle, plus directed scenarios
// with hand-computed edge-exact expectations.
module tb_supply_seq_driver;

   localparam int VDD_DLY = 8;
   localparam int SETTLE  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwr_req = 1'b0;
   logic sup_fault = 1'b0;
   logic in_data = 1'b0;
   logic vss_en, vdd_en, dut_in, pwr_good, busy, fault;

   supply_seq_driver #(.VDD_DLY(VDD_DLY), .SETTLE(SETTLE), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .pwr_req(pwr_req), .sup_fault(sup_fault), .in_data(in_data),
      .vss_en(vss_en), .vdd_en(vdd_en), .dut_in(dut_in), .pwr_good(pwr_good),
      .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int edge_no  = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Supply ladder model: lvl 0 = nothing, 1 = VSS, 2 = VSS+VDD, 3 = powered with input released.
   // wait_left counts edges until the next rung; down marks a committed power-down.
   typedef struct {
      int lvl;
      int wait_left;
      bit down;
      bit flt;
   } model_t;

   model_t m = '{lvl: 0, wait_left: 0, down: 1'b0, flt: 1'b0};

   function automatic model_t model_next(model_t s, logic r, logic req, logic sf);
      model_t n = s;
      if (r) begin
         n = '{lvl: 0, wait_left: 0, down: 1'b0, flt: 1'b0};
      end else if (s.flt) begin
         if (!sf && !req) n.flt = 1'b0;
      end else if (sf) begin
         n = '{lvl: 0, wait_left: 0, down: 1'b0, flt: 1'b1};
      end else if (s.lvl == 0) begin
         if (req) begin
            n.lvl = 1;
            n.wait_left = VDD_DLY;
         end
      end else if (s.lvl == 3) begin
         if (!req) begin
            n.lvl = 2;
            n.down = 1'b1;
            n.wait_left = SETTLE;
         end
      end else if (s.down) begin
         n.wait_left = s.wait_left - 1;
         if (n.wait_left == 0) begin
            n.lvl = s.lvl - 1;
            n.wait_left = VDD_DLY;
            if (n.lvl == 0) n.down = 1'b0;
         end
      end else if (!req) begin
         if (s.lvl == 1) begin
            n.lvl = 0;
         end else begin
            n.lvl = 1;
            n.down = 1'b1;
            n.wait_left = VDD_DLY;
         end
      end else begin
         n.wait_left = s.wait_left - 1;
         if (n.wait_left == 0) begin
            n.lvl = s.lvl + 1;
            n.wait_left = SETTLE;
         end
      end
      return n;
   endfunction

   always @(posedge clk) m <= model_next(m, rst, pwr_req, sup_fault);

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_vss_en",   vss_en,   (m.lvl >= 1) ? 1 : 0);
         check("m_vdd_en",   vdd_en,   (m.lvl >= 2) ? 1 : 0);
         check("m_pwr_good", pwr_good, (m.lvl == 3) ? 1 : 0);
         check("m_busy",     busy,     (m.lvl == 1 || m.lvl == 2) ? 1 : 0);
         check("m_fault",    fault,    m.flt ? 1 : 0);
         check("m_dut_in",   dut_in,   (m.lvl == 3) ? in_data : 1'b0);
         check("inv_vdd_needs_vss", vdd_en & ~vss_en, 0);
         check("inv_in_needs_vdd",  (dut_in | pwr_good) & ~vdd_en, 0);
      end
   end

   // Advance to relative edge k; inputs change 2 time units after each rising edge.
   task automatic adv(input int k);
      while (edge_no < k) begin
         @(posedge clk);
         #2;
         edge_no++;
         in_data = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk_en = 1'b1;
      check("rst_vss_en", vss_en, 0);
      check("rst_vdd_en", vdd_en, 0);
      check("rst_pwr_good", pwr_good, 0);
      check("rst_busy", busy, 0);
      check("rst_fault", fault, 0);
      in_data = 1'b1; #1;
      check("rst_dut_in", dut_in, 0);
      rst = 1'b0;
      edge_no = 0; adv(3);

      // Nominal power-up.
      edge_no = 0; pwr_req = 1'b1;
      adv(1);  check("up_vss_e1", vss_en, 1); check("up_vdd_e1", vdd_en, 0); check("up_busy_e1", busy, 1);
      adv(8);  check("up_vdd_e8", vdd_en, 0);
      adv(9);  check("up_vdd_e9", vdd_en, 1);
      adv(24); in_data = 1'b1; #1;
      check("up_dut_in_e24", dut_in, 0); check("up_good_e24", pwr_good, 0);
      adv(25); check("up_good_e25", pwr_good, 1); check("up_busy_e25", busy, 0);
      in_data = 1'b1; #1; check("up_dut_in_hi", dut_in, 1);
      in_data = 1'b0; #1; check("up_dut_in_lo", dut_in, 0);
      adv(30);

      // Nominal power-down.
      edge_no = 0; pwr_req = 1'b0;
      adv(1);  check("dn_good_e1", pwr_good, 0); check("dn_busy_e1", busy, 1); check("dn_vdd_e1", vdd_en, 1);
      in_data = 1'b1; #1; check("dn_dut_in_e1", dut_in, 0);
      adv(16); check("dn_vdd_e16", vdd_en, 1);
      adv(17); check("dn_vdd_e17", vdd_en, 0); check("dn_vss_e17", vss_en, 1);
      adv(24); check("dn_vss_e24", vss_en, 1);
      adv(25); check("dn_vss_e25", vss_en, 0); check("dn_busy_e25", busy, 0);
      adv(28);

      // Abort while only VSS is up.
      edge_no = 0; pwr_req = 1'b1;
      adv(4);  pwr_req = 1'b0;
      adv(5);  check("ab1_vss_e5", vss_en, 0); check("ab1_vdd_e5", vdd_en, 0); check("ab1_busy_e5", busy, 0);
      adv(15);

      // Abort while VDD is up but not yet settled.
      edge_no = 0; pwr_req = 1'b1;
      adv(12); pwr_req = 1'b0;
      adv(13); check("ab2_vdd_e13", vdd_en, 0); check("ab2_vss_e13", vss_en, 1); check("ab2_busy_e13", busy, 1);
      adv(20); check("ab2_vss_e20", vss_en, 1);
      adv(21); check("ab2_vss_e21", vss_en, 0);
      adv(24);

      // Supply fault from GOOD.
      edge_no = 0; pwr_req = 1'b1;
      adv(30); sup_fault = 1'b1;
      adv(31); check("flt_fault_e31", fault, 1); check("flt_vss_e31", vss_en, 0);
      check("flt_vdd_e31", vdd_en, 0); check("flt_good_e31", pwr_good, 0); check("flt_busy_e31", busy, 0);
      in_data = 1'b1; #1; check("flt_dut_in_e31", dut_in, 0);
      sup_fault = 1'b0;
      adv(36); check("flt_hold_e36", fault, 1);
      pwr_req = 1'b0;
      adv(37); check("flt_exit_e37", fault, 0); check("flt_exit_vss", vss_en, 0);
      adv(40);

      // Re-request during DRAIN is not latched; power-down completes first.
      edge_no = 0; pwr_req = 1'b1;
      adv(30);
      edge_no = 0; pwr_req = 1'b0;
      adv(5);  pwr_req = 1'b1;
      adv(7);  pwr_req = 1'b0;
      adv(10); pwr_req = 1'b1;
      adv(17); check("rr_vdd_e17", vdd_en, 0); check("rr_vss_e17", vss_en, 1);
      adv(25); check("rr_vss_e25", vss_en, 0); check("rr_busy_e25", busy, 0);
      adv(26); check("rr_vss_e26", vss_en, 1);
      adv(33); check("rr_vdd_e33", vdd_en, 0);
      adv(34); check("rr_vdd_e34", vdd_en, 1);
      adv(49); check("rr_good_e49", pwr_good, 0);
      adv(50); check("rr_good_e50", pwr_good, 1);
      pwr_req = 1'b0;
      adv(80);

      // Reset in the middle of VDD settle.
      edge_no = 0; pwr_req = 1'b1;
      adv(12); rst = 1'b1;
      adv(13); check("mr_vss_e13", vss_en, 0); check("mr_vdd_e13", vdd_en, 0);
      check("mr_busy_e13", busy, 0); check("mr_good_e13", pwr_good, 0); check("mr_fault_e13", fault, 0);
      rst = 1'b0;
      adv(14); check("mr_vss_e14", vss_en, 1);
      adv(21); check("mr_vdd_e21", vdd_en, 0);
      adv(22); check("mr_vdd_e22", vdd_en, 1);
      adv(37); check("mr_good_e37", pwr_good, 0);
      adv(38); check("mr_good_e38", pwr_good, 1);
      pwr_req = 1'b0;
      adv(70);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/supply_seq_driver.md
Name: supply_seq_driver

Overview:
- Active supply driver for the `_w_sup` wrapper cells. It replaces the constant `VDD_val`/`VSS_val` tie-offs in the top-level netlist wrapper with ordered enables.
- Power-up order: VSS first, then VDD, then DUT input release. Power-down runs in the reverse order.
- Drives the supply pins and the DUT `in` pin of a `TEST__w_sup`-style instance, including a fault path for emergency shutdown.

Parameters:
- VDD_DLY, 8, cycles between vss_en edge and vdd_en edge (both directions); legal range 1..2^CNT_W-1.
- SETTLE, 16, cycles between vdd_en edge and input-gate edge (both directions); legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the shared delay counter.

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous, active-high reset
- pwr_req  input  1  level request: 1 = powered, 0 = off
- sup_fault  input  1  supply fault; forces immediate shutdown
- in_data  input  1  functional input destined for DUT `in`
- vss_en  output  1  drives DUT VSS pin (1 = VSS connected)
- vdd_en  output  1  drives DUT VDD pin (1 = VDD connected)
- dut_in  output  1  DUT `in` pin; in_data gated by in_gate
- pwr_good  output  1  high only in state GOOD
- busy  output  1  high in any transitional state (VSS_ON, VDD_ON, DRAIN, VDD_OFF)
- fault  output  1  high in state FAULT

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=OFF, counter=0.
  - vss_en, vdd_en, pwr_good, busy and fault are all 0; the internal in_gate is 0.
  - Reset overrides everything, including mid-sequence, and drops all supplies in the same edge.
- All outputs are registered, except dut_in = in_gate ? in_data : 0, which is combinational.
- States and transitions (counter reloads to 0 on every state entry and increments each cycle within the state):
  - OFF: pwr_req=1 -> VSS_ON; vss_en=1 from the next edge.
  - VSS_ON: counter==VDD_DLY-1 -> VDD_ON, vdd_en=1. pwr_req=0 -> OFF, vss_en=0 next edge.
  - VDD_ON: counter==SETTLE-1 -> GOOD, in_gate=1, pwr_good=1. pwr_req=0 -> VDD_OFF, vdd_en=0 next edge.
  - GOOD: pwr_req=0 -> DRAIN; in_gate=0 and pwr_good=0 next edge.
  - DRAIN: counter==SETTLE-1 -> VDD_OFF, vdd_en=0. pwr_req is ignored.
  - VDD_OFF: counter==VDD_DLY-1 -> OFF, vss_en=0. pwr_req is ignored.
  - FAULT: all supplies, in_gate, pwr_good and busy are 0; fault=1. Exit to OFF only when sup_fault=0 and pwr_req=0 in the same cycle.
- Resulting latency:
  - From the pwr_req rise sampled at edge T: vss_en high after T, vdd_en high after T+VDD_DLY, pwr_good high after T+VDD_DLY+SETTLE.
  - Power-down is symmetric.
- sup_fault=1 in any non-FAULT state -> FAULT at the next edge. Fault has priority over every other transition, with no sequencing on the way down.
- Invariants:
  - vdd_en=1 implies vss_en=1.
  - in_gate=1 implies vdd_en=1.
  - pwr_good == (state==GOOD).
- Re-request: a pwr_req rise during DRAIN/VDD_OFF is not latched. A new power-up starts only from OFF with pwr_req still high. OFF then immediately goes to VSS_ON, with no idle cycle required beyond the OFF cycle.
- Counter saturates; it never wraps within a state because the parameter bounds are enforced by an elaboration assertion.

Test Plan:
- Nominal power-up (defaults): rst, then pwr_req=1 at edge 0.
  - Required: vss_en=1 after edge 1, vdd_en=1 after edge 9, pwr_good=1 after edge 25.
  - dut_in follows in_data only from edge 25 onward; before that dut_in=0 while in_data toggles.
- Nominal power-down: from GOOD, pwr_req=0 at edge N.
  - Required: pwr_good=0 and dut_in=0 after N+1, vdd_en=0 after N+17, vss_en=0 after N+25.
  - busy is high throughout; the bench asserts the ordering invariants every cycle.
- Abort mid-up: pwr_req=0 while in VSS_ON (cycle 4).
  - Required: vss_en=0 next edge, state OFF, vdd_en never asserts.
  - Repeat in VDD_ON: vdd_en=0 next edge, vss_en=0 VDD_DLY=8 edges later.
- Fault: sup_fault=1 while in GOOD.
  - Required: next edge vss_en=vdd_en=pwr_good=dut_in=0 and fault=1.
  - Holding pwr_req=1 with sup_fault=0 keeps FAULT; pwr_req=0 with sup_fault=0 returns to OFF.
- Re-request during drain: pwr_req 1->0->1 within DRAIN.
  - Required: full power-down completes (vss_en=0), one OFF cycle follows, then a new power-up with the same timing as the first scenario.
- Reset mid-sequence: rst=1 while in VDD_ON with pwr_req=1.
  - Required: all outputs 0 after that edge.
  - After rst deasserts, power-up restarts from VSS_ON with full delays.
